// File: rtl/gate_stim_checker.sv
// Self-checking stimulus driver for a two-input AND cell: walks the four input vectors,
// samples the cell output after a settle delay and accumulates an error count and fail map.
// Optional macro GATE_STIM_CHECKER_SYNC_EN adds a 2-flop synchronizer on out1.
module gate_stim_checker #(
    parameter int SETTLE = 3,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             loop,
    input  logic             out1,
    output logic             in1,
    output logic             in2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

`ifdef GATE_STIM_CHECKER_SYNC_EN
    localparam int EFF_SETTLE = SETTLE + 2;
`else
    localparam int EFF_SETTLE = SETTLE;
`endif
    localparam int CNT_W = (EFF_SETTLE < 2) ? 1 : $clog2(EFF_SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EFF_SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic             mismatch_q, mismatch_d;
    logic             in1_q, in1_d;
    logic             in2_q, in2_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic             obs_s;
    logic             exp_s;
    logic [1:0]       vec_next_s;

`ifdef GATE_STIM_CHECKER_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-stage synchronizer for cell models that settle asynchronously to clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= out1;
            sync2_q <= sync1_q;
        end
    end

    assign obs_s = sync2_q;
`else
    assign obs_s = out1;
`endif

    assign exp_s      = vec_q[0] & vec_q[1];
    assign vec_next_s = vec_q + 2'd1;

    // Next-state and registered-output computation for the vector walk.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        mismatch_d = mismatch_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_d     = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    cnt_d      = '0;
                    vec_d      = 2'd0;
                    mismatch_d = 1'b0;
                    in1_d      = 1'b0;
                    in2_d      = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    fail_d     = 4'b0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    mismatch_d = obs_s ^ exp_s;
                    state_d    = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                // Result of the previous edge's comparison lands here, one edge later.
                if (mismatch_q) begin
                    fail_d[vec_q] = 1'b1;
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    err_d = err_q;
                end
                mismatch_d = 1'b0;
                if ((vec_q != 2'd3) || loop) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    vec_d   = vec_next_s;
                    in1_d   = vec_next_s[0];
                    in2_d   = vec_next_s[1];
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    vec_d   = 2'd0;
                    in1_d   = 1'b0;
                    in2_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                vec_d      = 2'd0;
                mismatch_d = 1'b0;
                in1_d      = 1'b0;
                in2_d      = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears every partial result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            vec_q      <= 2'd0;
            mismatch_q <= 1'b0;
            in1_q      <= 1'b0;
            in2_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= 4'b0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vec_q      <= vec_d;
            mismatch_q <= mismatch_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
        end
    end

    assign in1      = in1_q;
    assign in2      = in2_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: a behavioural cell model (AND, stuck-at, OR)
// closes the loop on in1/in2 -> out1; outputs are sampled on the falling edge.
module tb_gate_stim_checker;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       loop;
    logic       out1;
    logic       in1;
    logic       in2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [3:0] fail_vec;

    int mode;
    int errs;
    int checks;

    gate_stim_checker #(.SETTLE(3), .ERR_W(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .loop     (loop),
        .out1     (out1),
        .in1      (in1),
        .in2      (in2),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell model: 0 = AND, 1 = stuck-at-0, 2 = stuck-at-1, 3 = OR.
    always_comb begin
        case (mode)
            0:       out1 = in1 & in2;
            1:       out1 = 1'b0;
            2:       out1 = 1'b1;
            3:       out1 = in1 | in2;
            default: out1 = in1 & in2;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds start across exactly one rising edge (E0), returns at the following negedge.
    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", {31'd0, done}, 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        check(tag, {22'd0, in1, in2, busy, done, pass, fail_vec, err_cnt}, 32'd0);
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        mode   = 0;
        rstn   = 1'b0;
        start  = 1'b0;
        loop   = 1'b0;
        tick(3);
        check_idle_zero("reset_state");
        rstn = 1'b1;
        tick(2);

        // 1: ideal AND, vectors at E0, +4, +8, +12; done at +16.
        mode = 0;
        kick();
        check("t1_v0", {30'd0, in1, in2}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        tick(4);
        check("t1_v1", {30'd0, in1, in2}, 32'd2);
        tick(4);
        check("t1_v2", {30'd0, in1, in2}, 32'd1);
        tick(4);
        check("t1_v3", {30'd0, in1, in2}, 32'd3);
        tick(3);
        check("t1_done_early", {30'd0, busy, done}, 32'd2);
        tick(1);
        check("t1_done", {30'd0, busy, done}, 32'd1);
        check("t1_pass", {31'd0, pass}, 32'd1);
        check("t1_err", {24'd0, err_cnt}, 32'd0);
        check("t1_fail", {28'd0, fail_vec}, 32'd0);
        check("t1_in_idle", {30'd0, in1, in2}, 32'd0);

        // 2: stuck-at-0 -> only vector 3 mismatches.
        tick(2);
        mode = 1;
        kick();
        tick(16);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_err", {24'd0, err_cnt}, 32'd1);
        check("t2_fail", {28'd0, fail_vec}, 32'd8);
        check("t2_pass", {31'd0, pass}, 32'd0);

        // 3: OR cell -> vectors 1 and 2 mismatch.
        tick(2);
        mode = 3;
        kick();
        tick(16);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_err", {24'd0, err_cnt}, 32'd2);
        check("t3_fail", {28'd0, fail_vec}, 32'd6);
        check("t3_pass", {31'd0, pass}, 32'd0);

        // 4: loop with stuck-at-1 for 90 passes: 3 errors per pass saturates at 255.
        tick(2);
        mode = 2;
        loop = 1'b1;
        kick();
        tick(90 * 16);
        check("t4_busy_loop", {30'd0, busy, done}, 32'd2);
        loop = 1'b0;
        wait_done(40);
        check("t4_err_sat", {24'd0, err_cnt}, 32'd255);
        check("t4_fail", {28'd0, fail_vec}, 32'd7);
        check("t4_pass", {31'd0, pass}, 32'd0);

        // 5: reset during vector 2 clears everything at once; a fresh run passes.
        tick(2);
        mode = 0;
        kick();
        tick(10);
        check("t5_mid_v2", {30'd0, in1, in2}, 32'd1);
        rstn = 1'b0;
        #1;
        check_idle_zero("t5_async_clear");
        tick(2);
        rstn = 1'b1;
        tick(1);
        kick();
        tick(15);
        check("t5_not_yet", {31'd0, done}, 32'd0);
        tick(1);
        check("t5_done", {31'd0, done}, 32'd1);
        check("t5_pass", {31'd0, pass}, 32'd1);
        check("t5_err", {24'd0, err_cnt}, 32'd0);

        // 6: start ignored while busy and on the done edge, accepted one edge later.
        tick(2);
        mode = 3;
        kick();
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t6_busy_ignore", {30'd0, busy, done}, 32'd2);
        tick(10);
        start = 1'b1;
        tick(1);
        check("t6_done_edge", {30'd0, busy, done}, 32'd1);
        check("t6_err_held", {24'd0, err_cnt}, 32'd2);
        tick(1);
        start = 1'b0;
        check("t6_accept", {30'd0, busy, done}, 32'd2);
        check("t6_err_clr", {24'd0, err_cnt}, 32'd0);
        check("t6_fail_clr", {28'd0, fail_vec}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
